onehot_sweep_encoder: RTL and testbench

- Encode-direction counterpart of the team's 4-to-16 decoder.
- Accepts a 16-bit bit-vector on a valid/ready interface and emits the index of every set bit, lowest first, one index per handshake on a 4-bit output.
- Output carries last and none flags, so a downstream 4-to-16 decoder can rebuild the vector one bit at a time.
- Sits between request-collection logic and any index-consuming stage (decoder, address generator).

---
 rtl/enc_pkg.sv | 14 +
 rtl/lsb_finder.sv | 48 ++++
 rtl/onehot_sweep_encoder.sv | 133 +++++++++++++
 tb/tb_onehot_sweep_encoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// enc_pkg: shared constants and state type for the one-hot sweep encoder.
// ENC_W / ENC_AW also size the companion 4-to-16 decoder instances, so the
// encoder and decoder always agree on vector and index widths.
package enc_pkg;

  localparam int ENC_W  = 16;
  localparam int ENC_AW = $clog2(ENC_W);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

endpackage : enc_pkg

// File: rtl/lsb_finder.sv
// lsb_finder: combinational W-to-AW priority encoder favouring the lowest bit.
// Ports:
//   mask   - input vector to search
//   idx    - index of the lowest set bit (0 when mask is zero)
//   any    - mask has at least one bit set
//   single - mask has exactly one bit set
module lsb_finder
  import enc_pkg::*;
#(
  parameter  int W  = ENC_W,
  localparam int AW = $clog2(W)
) (
  input  logic [W-1:0]  mask,
  output logic [AW-1:0] idx,
  output logic          any,
  output logic          single
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic          found_s;
  logic [AW-1:0] idx_s;
  logic [W-1:0]  rest_s;

  // Scan upward; the first set bit seen wins, later bits are ignored.
  always_comb begin
    idx_s   = {AW{1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (mask[i] && !found_s) begin
        idx_s   = AW'(i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  always_comb begin
    rest_s = mask & (mask - ONE);
  end

  assign idx    = idx_s;
  assign any    = found_s;
  assign single = found_s && (rest_s == {W{1'b0}});

endmodule : lsb_finder

// File: rtl/onehot_sweep_encoder.sv
// onehot_sweep_encoder: accepts a W-bit vector and emits the index of every
// set bit, lowest first, one index per output handshake. An all-zero vector
// yields a single beat flagged with out_none.
// Ports:
//   clk, rst_n          - rising-edge clock, async active-low reset
//   in_vec, in_valid    - vector to encode and its qualifier
//   in_ready            - high only in IDLE (registered, no path from out_ready)
//   out_idx             - index of the current set bit
//   out_valid/out_ready - output beat handshake
//   out_last            - current beat is the final one for this vector
//   out_none            - vector was all-zero (out_idx = 0 on that beat)
module onehot_sweep_encoder
  import enc_pkg::*;
#(
  parameter  int W  = ENC_W,
  localparam int AW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  in_vec,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] out_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          out_none
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  enc_state_t    state_r;
  logic [W-1:0]  mask_r;
  logic          in_ready_r;
  logic [AW-1:0] out_idx_r;
  logic          out_valid_r;
  logic          out_last_r;
  logic          out_none_r;

  logic [W-1:0]  rest_s;
  logic [W-1:0]  src_s;
  logic [AW-1:0] f_idx_s;
  logic          f_any_s;
  logic          f_single_s;

  // mask_r holds the bit currently on out_idx; rest_s is what remains after it.
  always_comb begin
    rest_s = mask_r & (mask_r - ONE);
  end

  // One finder serves both cases: the fresh vector on accept, the remainder
  // on a beat handshake, so the next index is ready at the same edge.
  always_comb begin
    if (state_r == IDLE) begin
      src_s = in_vec;
    end else begin
      src_s = rest_s;
    end
  end

  lsb_finder #(.W(W)) u_lsb_finder (
    .mask   (src_s),
    .idx    (f_idx_s),
    .any    (f_any_s),
    .single (f_single_s)
  );

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      mask_r      <= {W{1'b0}};
      in_ready_r  <= 1'b1;
      out_idx_r   <= {AW{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_none_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_r     <= EMIT;
            mask_r      <= in_vec;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
            out_idx_r   <= f_idx_s;
            // A zero vector still produces exactly one (last, none) beat.
            out_last_r  <= f_single_s || !f_any_s;
            out_none_r  <= !f_any_s;
          end else begin
            state_r <= IDLE;
          end
        end
        EMIT: begin
          if (out_valid_r && out_ready) begin
            if (out_last_r) begin
              state_r     <= IDLE;
              mask_r      <= {W{1'b0}};
              in_ready_r  <= 1'b1;
              out_valid_r <= 1'b0;
              out_idx_r   <= {AW{1'b0}};
              out_last_r  <= 1'b0;
              out_none_r  <= 1'b0;
            end else begin
              mask_r     <= rest_s;
              out_idx_r  <= f_idx_s;
              out_last_r <= f_single_s;
              out_none_r <= 1'b0;
            end
          end else begin
            state_r <= EMIT;
          end
        end
        default: begin
          state_r     <= IDLE;
          mask_r      <= {W{1'b0}};
          in_ready_r  <= 1'b1;
          out_idx_r   <= {AW{1'b0}};
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          out_none_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_idx   = out_idx_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_none  = out_none_r;

endmodule : onehot_sweep_encoder

// File: tb/tb_onehot_sweep_encoder.sv
// Scoreboard bench for onehot_sweep_encoder: stimulus pushes expected beats,
// a negedge monitor pops and compares on every output handshake.
module tb_onehot_sweep_encoder;

  typedef struct packed {
    logic [3:0] idx;
    logic       last;
    logic       none;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_vec;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_none;

  int tests;
  int fails;

  beat_t       exp_q[$];
  logic [15:0] vec_q[$];

  beat_t       e;
  beat_t       saved;
  logic        stalled_prev;
  logic [15:0] recon;
  logic [15:0] v_exp;

  onehot_sweep_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_none  (out_none)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: stall stability, beat scoreboard and loopback reconstruction.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 1'b0;
      recon        = 16'h0000;
    end else begin
      if (out_valid && stalled_prev) begin
        tests++;
        if ({out_idx, out_last, out_none} !== saved) begin
          fails++;
          $display("FAIL stall_hold: got %h required %h", {out_idx, out_last, out_none}, saved);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got idx=%0d last=%0b none=%0b, required no beat",
                   out_idx, out_last, out_none);
        end else begin
          e = exp_q.pop_front();
          if (out_idx !== e.idx || out_last !== e.last || out_none !== e.none) begin
            fails++;
            $display("FAIL beat: got idx=%0d last=%0b none=%0b required idx=%0d last=%0b none=%0b",
                     out_idx, out_last, out_none, e.idx, e.last, e.none);
          end
          if (!out_none) recon = recon | (16'h0001 << out_idx);
          if (out_last && vec_q.size() > 0) begin
            v_exp = vec_q.pop_front();
            tests++;
            if (recon !== v_exp) begin
              fails++;
              $display("FAIL loopback: got %h required %h", recon, v_exp);
            end
            recon = 16'h0000;
          end
        end
      end
      stalled_prev = out_valid && !out_ready;
      saved        = {out_idx, out_last, out_none};
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic push(input logic [3:0] idx, input logic last, input logic none);
    beat_t b;
    b.idx  = idx;
    b.last = last;
    b.none = none;
    exp_q.push_back(b);
  endtask

  // Bench-side model used for random vectors: ascending bit scan.
  task automatic push_model(input logic [15:0] v);
    int hi;
    hi = -1;
    for (int i = 0; i < 16; i++) if (v[i]) hi = i;
    if (hi < 0) push(4'd0, 1'b1, 1'b1);
    else for (int i = 0; i < 16; i++) if (v[i]) push(4'(i), (i == hi), 1'b0);
    vec_q.push_back(v);
  endtask

  // Issue one vector and drain nb beats; optionally toggle out_ready 1,0,1,0.
  task automatic run(input logic [15:0] v, input bit toggle, input int nb);
    int n_hs;
    int cyc;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    in_vec    = v;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_hs = 0;
    cyc  = 0;
    while (n_hs < nb && cyc < 200) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (in_ready !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL in_ready_emit: got %0b required 0", in_ready);
      end
      if (out_valid && out_ready) n_hs++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("beat_count", n_hs, nb);
    chk("in_ready_after", {31'd0, in_ready}, 32'd1);
    if (!toggle) chk("cycles", cyc, nb);
    out_ready = 1'b1;
  endtask

  initial begin
    logic [15:0] rv;
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_vec    = 16'h0000;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_idx", {28'd0, out_idx}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_none", {31'd0, out_none}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single bit 0.
    push(4'd0, 1'b1, 1'b0); vec_q.push_back(16'h0001);
    run(16'h0001, 1'b0, 1);

    // Both ends.
    push(4'd0, 1'b0, 1'b0); push(4'd15, 1'b1, 1'b0); vec_q.push_back(16'h8001);
    run(16'h8001, 1'b0, 2);

    // Zero vector.
    push(4'd0, 1'b1, 1'b1); vec_q.push_back(16'h0000);
    run(16'h0000, 1'b0, 1);

    // All ones with stalls.
    for (int i = 0; i < 16; i++) push(4'(i), (i == 15), 1'b0);
    vec_q.push_back(16'hFFFF);
    run(16'hFFFF, 1'b1, 16);

    // Mid-burst reset after the index-5 beat.
    push(4'd4, 1'b0, 1'b0); push(4'd5, 1'b0, 1'b0);
    in_vec   = 16'h00F0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_idx", {28'd0, out_idx}, 32'd6);
    rst_n = 1'b0;
    #1;
    chk("rst_drop_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("rel_no_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_queue_drained", exp_q.size(), 0);

    // in_valid held high across two vectors.
    push(4'd1, 1'b0, 1'b0); push(4'd2, 1'b1, 1'b0); vec_q.push_back(16'h0006);
    push(4'd8, 1'b1, 1'b0); vec_q.push_back(16'h0100);
    in_vec   = 16'h0006;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_vec = 16'h0100;
    chk("hold_rdy0", {31'd0, in_ready}, 32'd0);
    chk("hold_idx1", {28'd0, out_idx}, 32'd1);
    @(posedge clk); #1;
    chk("hold_rdy1", {31'd0, in_ready}, 32'd0);
    chk("hold_idx2", {28'd0, out_idx}, 32'd2);
    @(posedge clk); #1;
    chk("hold_rdy2", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold_rdy3", {31'd0, in_ready}, 32'd0);
    chk("hold_idx8", {28'd0, out_idx}, 32'd8);
    @(posedge clk); #1;
    chk("hold_rdy4", {31'd0, in_ready}, 32'd1);

    // Random loopback.
    for (int k = 0; k < 1000; k++) begin
      rv = 16'($urandom);
      if (k % 50 == 0) rv = 16'h0000;
      push_model(rv);
      run(rv, (k % 3 == 0), ($countones(rv) == 0) ? 1 : $countones(rv));
    end

    repeat (2) @(posedge clk);
    #1;
    chk("final_exp_q_empty", exp_q.size(), 0);
    chk("final_vec_q_empty", vec_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_onehot_sweep_encoder
